bit_serializer: RTL and testbench

//   Parallel-to-serial stage that feeds the serial sequence-detector FSMs.

---
 rtl/bit_serializer.sv | 145 ++++++++++++++
 tb/tb_bit_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage with a valid/ready input handshake.
// Each accepted WIDTH-bit word is shifted out one bit per clock on dout.
// A new word can be accepted while the final bit of the current word is on
// dout, so back-to-back words form a gap-free bit stream.
// All outputs decode from registered state only, with no path from din/din_valid.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   logic             state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             head_s;
   logic             load_s;

   // Advance the shift register one place toward the head; the vacated bit fills with 0.
   function automatic logic [WIDTH-1:0] shift_to_head(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (MSB_FIRST) begin
         r = {v[WIDTH-2:0], 1'b0};
      end else begin
         r = {1'b0, v[WIDTH-1:1]};
      end
      return r;
   endfunction

   // Select the bit currently at the output end of the shift register.
   always_comb begin
      if (MSB_FIRST) begin
         head_s = shreg_q[WIDTH-1];
      end else begin
         head_s = shreg_q[0];
      end
   end

   // Moore output decode from state, counter and shift register.
   always_comb begin
      din_ready  = 1'b1;
      dout_valid = 1'b0;
      dout       = IDLE_BIT;
      last_bit   = 1'b0;
      busy       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            din_ready  = 1'b1;
            dout_valid = 1'b0;
            dout       = IDLE_BIT;
            last_bit   = 1'b0;
            busy       = 1'b0;
         end
         ST_SHIFT: begin
            din_ready  = (cnt_q == CNT_ZERO);
            dout_valid = 1'b1;
            dout       = head_s;
            last_bit   = (cnt_q == CNT_ZERO);
            busy       = 1'b1;
         end
         default: begin
            din_ready  = 1'b1;
            dout_valid = 1'b0;
            dout       = IDLE_BIT;
            last_bit   = 1'b0;
            busy       = 1'b0;
         end
      endcase
   end

   // A word is taken whenever the source offers one while we are ready.
   always_comb begin
      load_s = din_valid & din_ready;
   end

   // Next-state logic: load, shift, reload on the final bit, or return to idle.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (load_s) begin
               state_d = ST_SHIFT;
               shreg_d = din;
               cnt_d   = CNT_LAST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != CNT_ZERO) begin
               shreg_d = shift_to_head(shreg_q);
               cnt_d   = cnt_q - CNT_ONE;
            end else if (load_s) begin
               // Final bit on dout and a new word waiting: reload with no gap.
               state_d = ST_SHIFT;
               shreg_d = din;
               cnt_d   = CNT_LAST;
            end else begin
               state_d = ST_IDLE;
               shreg_d = {WIDTH{1'b0}};
               cnt_d   = CNT_ZERO;
            end
         end
         default: begin
            state_d = ST_IDLE;
            shreg_d = {WIDTH{1'b0}};
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State registers; reset drops any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= {WIDTH{1'b0}};
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench with a bit-level scoreboard.
// Two instances: A (MSB first, idle 0) and B (LSB first, idle 1).
// Each accepted word pushes its expected {last,bit} entries; every cycle the
// outputs are compared against the head of the queue at the falling edge.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] din_a = 8'h00;
   logic       valid_a = 1'b0;
   logic       ready_a, dout_a, dv_a, lb_a, busy_a;
   logic [7:0] din_b = 8'h00;
   logic       valid_b = 1'b0;
   logic       ready_b, dout_b, dv_b, lb_b, busy_b;

   logic [1:0] q_a[$];
   logic [1:0] q_b[$];

   int         pass_cnt = 0;
   int         fail_cnt = 0;
   int         total_cnt = 0;

   logic       obs_rdy_a, obs_dv_a, obs_lb_a;
   logic [3:0] det_win = 4'b0000;
   int         det_hits = 0;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(valid_a),
      .din_ready(ready_a), .dout(dout_a), .dout_valid(dv_a),
      .last_bit(lb_a), .busy(busy_a));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(valid_b),
      .din_ready(ready_b), .dout(dout_b), .dout_valid(dv_b),
      .last_bit(lb_b), .busy(busy_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input int sel, input logic [7:0] w, input bit msb);
      for (int i = 0; i < 8; i++) begin
         logic b;
         b = msb ? w[7-i] : w[i];
         if (sel == 0) q_a.push_back({(i == 7), b});
         else          q_b.push_back({(i == 7), b});
      end
   endtask

   task automatic check_dut(input string tag, input int sel, input logic dv, input logic d,
                            input logic lb, input logic rdy, input logic bsy, input logic idle_bit);
      logic [1:0] e;
      bit         have;
      e = 2'b00;
      if (sel == 0) begin
         have = (q_a.size() != 0);
         if (have) e = q_a.pop_front();
      end else begin
         have = (q_b.size() != 0);
         if (have) e = q_b.pop_front();
      end
      chk({tag, "_valid"}, {31'd0, dv}, {31'd0, have});
      chk({tag, "_busy"}, {31'd0, bsy}, {31'd0, have});
      chk({tag, "_ready"}, {31'd0, rdy}, {31'd0, (!have || e[1])});
      if (have) begin
         chk({tag, "_dout"}, {31'd0, d}, {31'd0, e[0]});
         chk({tag, "_last"}, {31'd0, lb}, {31'd0, e[1]});
      end else begin
         chk({tag, "_idle"}, {31'd0, d}, {31'd0, idle_bit});
         chk({tag, "_last0"}, {31'd0, lb}, 32'd0);
      end
   endtask

   // One clock: check both DUTs at the falling edge, record handshakes, pass the rising edge.
   task automatic cycle(input string tag);
      bit hs_a, hs_b;
      @(negedge clk);
      obs_rdy_a = ready_a;
      obs_dv_a  = dv_a;
      obs_lb_a  = lb_a;
      if (dv_a) begin
         det_win = {det_win[2:0], dout_a};
         if (det_win == 4'b1011) det_hits++;
      end
      hs_a = valid_a && ready_a;
      hs_b = valid_b && ready_b;
      check_dut({tag, "_A"}, 0, dv_a, dout_a, lb_a, ready_a, busy_a, 1'b0);
      check_dut({tag, "_B"}, 1, dv_b, dout_b, lb_b, ready_b, busy_b, 1'b1);
      if (hs_a) push_word(0, din_a, 1'b1);
      if (hs_b) push_word(1, din_b, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] w, input string tag);
      din_a   = w;
      valid_a = 1'b1;
      cycle(tag);
      valid_a = 1'b0;
   endtask

   initial begin
      logic [15:0] rdy_mask;
      int          dv_cnt;
      int          lb_cnt;

      // Test 1: reset and idle.
      #1 rst_n = 1'b0;
      #2;
      chk("rst_dv_a", {31'd0, dv_a}, 32'd0);
      chk("rst_dout_a", {31'd0, dout_a}, 32'd0);
      chk("rst_ready_a", {31'd0, ready_a}, 32'd1);
      chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
      chk("rst_dout_b", {31'd0, dout_b}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cycle("t1_idle");

      // Test 2: single 8'hB0, MSB first; detector sees 1011 once.
      det_win  = 4'b0000;
      det_hits = 0;
      lb_cnt   = 0;
      send_a(8'hB0, "t2_hs");
      for (int i = 0; i < 9; i++) begin
         cycle("t2_bit");
         lb_cnt += int'(obs_lb_a);
      end
      chk("t2_det_hits", det_hits, 32'd1);
      chk("t2_last_count", lb_cnt, 32'd1);

      // Test 3: 8'hB0 then 8'h0B with valid held; 16 contiguous bits.
      din_a   = 8'hB0;
      valid_a = 1'b1;
      cycle("t3_hs");
      din_a    = 8'h0B;
      rdy_mask = 16'h0000;
      dv_cnt   = 0;
      for (int i = 1; i <= 16; i++) begin
         cycle("t3_bit");
         rdy_mask[i-1] = obs_rdy_a;
         dv_cnt += int'(obs_dv_a);
         if (i == 8) valid_a = 1'b0;
      end
      chk("t3_ready_pulses", {16'd0, rdy_mask}, 32'h0000_8080);
      chk("t3_valid_run", dv_cnt, 32'd16);
      cycle("t3_idle");

      // Test 4: 8'hFF offered during bit 3 waits until the last bit.
      send_a(8'hB0, "t4_hs");
      cycle("t4_bit1");
      cycle("t4_bit2");
      din_a   = 8'hFF;
      valid_a = 1'b1;
      cycle("t4_bit3");
      chk("t4_not_ready_bit3", {31'd0, obs_rdy_a}, 32'd0);
      for (int i = 4; i <= 7; i++) cycle("t4_bit");
      cycle("t4_bit8");
      chk("t4_ready_bit8", {31'd0, obs_rdy_a}, 32'd1);
      valid_a = 1'b0;
      for (int i = 0; i < 9; i++) cycle("t4_ff");

      // Test 5: reset during the 4th bit, then 8'hA5 serializes cleanly.
      send_a(8'hB0, "t5_hs");
      for (int i = 0; i < 3; i++) cycle("t5_bit");
      chk("t5_pre_dv", {31'd0, dv_a}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_dv", {31'd0, dv_a}, 32'd0);
      chk("t5_rst_dout", {31'd0, dout_a}, 32'd0);
      chk("t5_rst_ready", {31'd0, ready_a}, 32'd1);
      q_a.delete();
      q_b.delete();
      cycle("t5_inrst");
      cycle("t5_inrst");
      rst_n = 1'b1;
      cycle("t5_post");
      send_a(8'hA5, "t5_a5_hs");
      for (int i = 0; i < 9; i++) cycle("t5_a5");

      // Test 6: LSB-first instance with 8'h0D gives 1,0,1,1,0,0,0,0.
      din_b   = 8'h0D;
      valid_b = 1'b1;
      cycle("t6_hs");
      valid_b = 1'b0;
      for (int i = 0; i < 9; i++) cycle("t6_bit");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
